// File: rtl/lane_mux_rr.sv
// Four-lane round-robin multiplexer with a single registered output word {Y,S}.
// Define LANE_MUX_LOCK_EN to add in_last and hold the grant on one lane until a packet's last word.

// Per-lane slice: request qualification plus this lane's share of the AND-OR data mux.
module lane_mux_rr_lane #(
  parameter int W = 8
) (
  input  logic         vld,
  input  logic         locked,
  input  logic         is_ptr,
  input  logic         gnt,
  input  logic [W-1:0] data,
  output logic         req,
  output logic [W-1:0] data_gated
);
  // While a packet is locked, only the lane that owns it may request.
  assign req        = vld && (!locked || is_ptr);
  assign data_gated = gnt ? data : '0;
endmodule

module lane_mux_rr #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
`ifdef LANE_MUX_LOCK_EN
  input  logic [3:0]     in_last,
`endif
  output logic [3:0]     in_ready,
  output logic [W-1:0]   Y,
  output logic [1:0]     S,
  output logic           E,
  input  logic           out_ready
);
  localparam int NUM_LANES = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [W-1:0]                  y_q, y_d;
  logic [1:0]                    s_q, s_d;
  logic [1:0]                    ptr_q, ptr_d;
  logic                          locked;

  logic [NUM_LANES-1:0]          req;
  logic [NUM_LANES-1:0]          gnt_oh;
  logic [NUM_LANES-1:0][W-1:0]   lane_dat;
  logic [W-1:0]                  y_mux;
  logic [1:0]                    gnt_idx;
  logic                          gnt_any;
  logic                          load_slot;

`ifdef LANE_MUX_LOCK_EN
  logic                          lock_q, lock_d;
  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      lane_mux_rr_lane #(.W(W)) u_lane (
        .vld        (in_valid[k]),
        .locked     (locked),
        .is_ptr     (ptr_q == 2'(k)),
        .gnt        (gnt_oh[k]),
        .data       (in_data[k*W +: W]),
        .req        (req[k]),
        .data_gated (lane_dat[k])
      );
    end
  endgenerate

  // Search ptr+1 .. ptr+4 (mod 4); the last candidate is the previous winner.
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    gnt_oh  = '0;
    for (int i = 1; i <= NUM_LANES; i++) begin
      idx = ptr_q + 2'(i);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  always_comb begin
    y_mux = '0;
    for (int i = 0; i < NUM_LANES; i++) y_mux = y_mux | lane_dat[i];
  end

  assign load_slot = (state_q == EMPTY) || out_ready;
  // rst_n gates the strobe so nothing looks accepted while reset is held.
  assign in_ready  = (load_slot && rst_n) ? gnt_oh : '0;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
`ifdef LANE_MUX_LOCK_EN
    lock_d  = lock_q;
`endif
    if (load_slot) begin
      if (gnt_any) begin
        state_d = FULL;
        y_d     = y_mux;
        s_d     = gnt_idx;
        ptr_d   = gnt_idx;
`ifdef LANE_MUX_LOCK_EN
        lock_d  = !in_last[gnt_idx];
`endif
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      s_q     <= '0;
      ptr_q   <= 2'd3;
`ifdef LANE_MUX_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
`ifdef LANE_MUX_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign Y = y_q;
  assign S = s_q;
  assign E = (state_q == FULL);
endmodule
